// File: rtl/instruction_buffer.sv
// In-order queue of decoded 4-instruction groups: resolves operands at enqueue, wakes pending
// operands from ROB results and dispatches up to four per cycle to FXU0/FXU1/LSU/branch stations.
module instruction_buffer #(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instructions_valid,
  input  logic [15:0]  opcode_in,
  input  logic [3:0]   op_a_local_dep,
  input  logic [3:0]   op_b_local_dep,
  input  logic [15:0]  op_a_owner_in,
  input  logic [15:0]  op_b_owner_in,
  input  logic [15:0]  rt_in,
  input  logic [3:0]   uses_rb,
  input  logic [63:0]  ra_value,
  input  logic [63:0]  rb_value,
  input  logic [3:0]   ra_busy,
  input  logic [3:0]   rb_busy,
  input  logic [15:0]  ra_owner,
  input  logic [15:0]  rb_owner,
  input  logic [15:0]  rob_output_valid,
  input  logic [255:0] rob_output_values,
  input  logic         fxu_0_full,
  input  logic         fxu_1_full,
  input  logic         lsu_full,
  input  logic         branch_full,
  output logic [3:0]   num_slots,
  output logic [3:0]   out_valid,
  output logic [7:0]   out_unit,
  output logic [3:0]   out_a_valid,
  output logic [3:0]   out_b_valid,
  output logic [63:0]  out_a_value,
  output logic [63:0]  out_b_value,
  output logic [15:0]  out_a_owner,
  output logic [15:0]  out_b_owner,
  output logic [15:0]  out_rt,
  output logic [15:0]  opcode
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rt;
    logic        a_valid;
    logic [15:0] a_value;
    logic [3:0]  a_owner;
    logic        b_valid;
    logic [15:0] b_value;
    logic [3:0]  b_owner;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        enq_e [4];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          enq;
  logic [2:0]    n_disp;

  logic [3:0]  d_valid, d_a_valid, d_b_valid;
  logic [7:0]  d_unit;
  logic [63:0] d_a_value, d_b_value;
  logic [15:0] d_a_owner, d_b_owner, d_rt, d_op;

  assign enq       = instructions_valid && ((CW'(DEPTH) - count) >= CW'(4));
  assign num_slots = 4'(CW'(DEPTH) - count);

  // Operand source priority: in-group producer, then busy register, then register file.
  always_comb begin
    logic [3:0] a_own, b_own;
    for (int i = 0; i < 4; i++) begin
      enq_e[i]    = '0;
      enq_e[i].op = opcode_in[i*4 +: 4];
      enq_e[i].rt = rt_in[i*4 +: 4];
      a_own = op_a_local_dep[i] ? op_a_owner_in[i*4 +: 4] : ra_owner[i*4 +: 4];
      b_own = op_b_local_dep[i] ? op_b_owner_in[i*4 +: 4] : rb_owner[i*4 +: 4];
      if (op_a_local_dep[i] || ra_busy[i]) begin
        enq_e[i].a_owner = a_own;
        enq_e[i].a_valid = rob_output_valid[a_own];
        enq_e[i].a_value = rob_output_valid[a_own] ? rob_output_values[{a_own, 4'b0} +: 16] : 16'h0;
      end else begin
        enq_e[i].a_valid = 1'b1;
        enq_e[i].a_value = ra_value[i*16 +: 16];
      end
      if (!uses_rb[i]) begin
        enq_e[i].b_valid = 1'b1;
      end else if (op_b_local_dep[i] || rb_busy[i]) begin
        enq_e[i].b_owner = b_own;
        enq_e[i].b_valid = rob_output_valid[b_own];
        enq_e[i].b_value = rob_output_valid[b_own] ? rob_output_values[{b_own, 4'b0} +: 16] : 16'h0;
      end else begin
        enq_e[i].b_valid = 1'b1;
        enq_e[i].b_value = rb_value[i*16 +: 16];
      end
    end
  end

  // In-order scan; the first entry that finds no free unit blocks everything behind it.
  always_comb begin
    logic          u0, u1, ul, ub, stop, ok;
    logic [1:0]    unit;
    logic [PW-1:0] idx;
    entry_t        e;
    u0 = fxu_0_full;
    u1 = fxu_1_full;
    ul = lsu_full;
    ub = branch_full;
    stop = 1'b0;
    n_disp = '0;
    d_valid = '0; d_a_valid = '0; d_b_valid = '0; d_unit = '0;
    d_a_value = '0; d_b_value = '0; d_a_owner = '0; d_b_owner = '0; d_rt = '0; d_op = '0;
    for (int k = 0; k < 4; k++) begin
      idx  = head + PW'(k);
      e    = q[idx];
      ok   = 1'b0;
      unit = 2'd0;
      if (!stop && (CW'(k) < count)) begin
        case (e.op[3:2])
          2'b10:   if (!ul) begin ok = 1'b1; unit = 2'd2; ul = 1'b1; end
          2'b11:   if (!ub) begin ok = 1'b1; unit = 2'd3; ub = 1'b1; end
          default: begin
            if (!u0) begin ok = 1'b1; unit = 2'd0; u0 = 1'b1; end
            else if (!u1) begin ok = 1'b1; unit = 2'd1; u1 = 1'b1; end
          end
        endcase
      end
      if (ok) begin
        n_disp = n_disp + 3'd1;
        d_valid[k]          = 1'b1;
        d_unit[k*2 +: 2]    = unit;
        d_op[k*4 +: 4]      = e.op;
        d_rt[k*4 +: 4]      = e.rt;
        d_a_owner[k*4 +: 4] = e.a_owner;
        d_b_owner[k*4 +: 4] = e.b_owner;
        d_a_valid[k] = e.a_valid | rob_output_valid[e.a_owner];
        d_b_valid[k] = e.b_valid | rob_output_valid[e.b_owner];
        d_a_value[k*16 +: 16] = e.a_valid ? e.a_value :
                                rob_output_valid[e.a_owner] ? rob_output_values[{e.a_owner, 4'b0} +: 16] : 16'h0;
        d_b_value[k*16 +: 16] = e.b_valid ? e.b_value :
                                rob_output_valid[e.b_owner] ? rob_output_values[{e.b_owner, 4'b0} +: 16] : 16'h0;
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (!q[j].a_valid && rob_output_valid[q[j].a_owner]) begin
        q[j].a_valid <= 1'b1;
        q[j].a_value <= rob_output_values[{q[j].a_owner, 4'b0} +: 16];
      end
      if (!q[j].b_valid && rob_output_valid[q[j].b_owner]) begin
        q[j].b_valid <= 1'b1;
        q[j].b_value <= rob_output_values[{q[j].b_owner, 4'b0} +: 16];
      end
    end
    if (enq) begin
      for (int i = 0; i < 4; i++) q[tail + PW'(i)] <= enq_e[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0; tail <= '0; count <= '0;
      out_valid <= '0; out_unit <= '0; out_a_valid <= '0; out_b_valid <= '0;
      out_a_value <= '0; out_b_value <= '0; out_a_owner <= '0; out_b_owner <= '0;
      out_rt <= '0; opcode <= '0;
    end else begin
      head  <= head + PW'(n_disp);
      tail  <= enq ? tail + PW'(4) : tail;
      count <= count + (enq ? CW'(4) : CW'(0)) - CW'(n_disp);
      out_valid   <= d_valid;
      out_unit    <= d_unit;
      out_a_valid <= d_a_valid;
      out_b_valid <= d_b_valid;
      out_a_value <= d_a_value;
      out_b_value <= d_b_value;
      out_a_owner <= d_a_owner;
      out_b_owner <= d_b_owner;
      out_rt      <= d_rt;
      opcode      <= d_op;
    end
  end
endmodule

// File: tb/tb_instruction_buffer.sv
// Directed bench for instruction_buffer: scoreboard of expected dispatches in program order.
module tb_instruction_buffer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         instructions_valid;
  logic [15:0]  opcode_in, op_a_owner_in, op_b_owner_in, rt_in, ra_owner, rb_owner;
  logic [3:0]   op_a_local_dep, op_b_local_dep, uses_rb, ra_busy, rb_busy;
  logic [63:0]  ra_value, rb_value;
  logic [15:0]  rob_output_valid;
  logic [255:0] rob_output_values;
  logic         fxu_0_full, fxu_1_full, lsu_full, branch_full;
  logic [3:0]   num_slots, out_valid, out_a_valid, out_b_valid;
  logic [7:0]   out_unit;
  logic [63:0]  out_a_value, out_b_value;
  logic [15:0]  out_a_owner, out_b_owner, out_rt, opcode;

  instruction_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .instructions_valid(instructions_valid), .opcode_in(opcode_in),
    .op_a_local_dep(op_a_local_dep), .op_b_local_dep(op_b_local_dep),
    .op_a_owner_in(op_a_owner_in), .op_b_owner_in(op_b_owner_in), .rt_in(rt_in), .uses_rb(uses_rb),
    .ra_value(ra_value), .rb_value(rb_value), .ra_busy(ra_busy), .rb_busy(rb_busy),
    .ra_owner(ra_owner), .rb_owner(rb_owner), .rob_output_valid(rob_output_valid),
    .rob_output_values(rob_output_values), .fxu_0_full(fxu_0_full), .fxu_1_full(fxu_1_full),
    .lsu_full(lsu_full), .branch_full(branch_full), .num_slots(num_slots), .out_valid(out_valid),
    .out_unit(out_unit), .out_a_valid(out_a_valid), .out_b_valid(out_b_valid),
    .out_a_value(out_a_value), .out_b_value(out_b_value), .out_a_owner(out_a_owner),
    .out_b_owner(out_b_owner), .out_rt(out_rt), .opcode(opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rt;
    logic        av;
    logic [15:0] aval;
    logic [3:0]  aown;
    logic        bv;
    logic [15:0] bval;
    logic [3:0]  bown;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic sf0, sf1, sfl, sfb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a group of four; operand a = aval, operand b (slots 1,2) = aval^00FF.
  task automatic set_group(input logic [15:0] ops, input logic [15:0] rts, input logic [15:0] aval, input bit push);
    exp_t e;
    instructions_valid = 1'b1;
    opcode_in = ops; rt_in = rts; uses_rb = 4'b0110;
    op_a_local_dep = '0; op_b_local_dep = '0; op_a_owner_in = '0; op_b_owner_in = '0;
    ra_busy = '0; rb_busy = '0; ra_owner = '0; rb_owner = '0;
    ra_value = {4{aval}}; rb_value = {4{aval ^ 16'h00FF}};
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        e.op = ops[i*4 +: 4]; e.rt = rts[i*4 +: 4];
        e.av = 1'b1; e.aval = aval; e.aown = 4'h0;
        e.bv = 1'b1; e.bval = (i == 1 || i == 2) ? (aval ^ 16'h00FF) : 16'h0; e.bown = 4'h0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic fix_a(input int idx, input logic av, input logic [15:0] aval, input logic [3:0] aown);
    exp_t e;
    e = sb[idx]; e.av = av; e.aval = aval; e.aown = aown;
    sb[idx] = e;
  endtask

  // Pops one expectation per valid lane and re-derives the unit from the sampled full flags.
  task automatic collect(output int n);
    logic u0, u1, ul, ub, gap;
    logic [3:0] eu;
    exp_t e;
    u0 = sf0; u1 = sf1; ul = sfl; ub = sfb; gap = 1'b0; n = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k]) begin
        if (gap) chk("lane_contiguous", 32'd1, 32'd0);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          eu = 4'hF;
          if (e.op[3:2] == 2'b10) begin if (!ul) begin eu = 4'd2; ul = 1'b1; end end
          else if (e.op[3:2] == 2'b11) begin if (!ub) begin eu = 4'd3; ub = 1'b1; end end
          else if (!u0) begin eu = 4'd0; u0 = 1'b1; end
          else if (!u1) begin eu = 4'd1; u1 = 1'b1; end
          chk("unit", {2'b0, out_unit[k*2 +: 2]}, eu);
          chk("opcode", opcode[k*4 +: 4], e.op);
          chk("rt", out_rt[k*4 +: 4], e.rt);
          chk("a_valid", out_a_valid[k], e.av);
          chk("a_value", out_a_value[k*16 +: 16], e.aval);
          chk("a_owner", out_a_owner[k*4 +: 4], e.aown);
          chk("b_valid", out_b_valid[k], e.bv);
          chk("b_value", out_b_value[k*16 +: 16], e.bval);
          chk("b_owner", out_b_owner[k*4 +: 4], e.bown);
        end
        n++;
      end else begin
        gap = 1'b1;
        chk("idle_lane_zero", 32'(|{out_unit[k*2 +: 2], out_a_valid[k], out_b_valid[k],
            out_a_value[k*16 +: 16], out_b_value[k*16 +: 16], out_a_owner[k*4 +: 4],
            out_b_owner[k*4 +: 4], out_rt[k*4 +: 4], opcode[k*4 +: 4]}), 32'd0);
      end
    end
  endtask

  task automatic step(output int n);
    sf0 = fxu_0_full; sf1 = fxu_1_full; sfl = lsu_full; sfb = branch_full;
    @(posedge clk);
    #1;
    instructions_valid = 1'b0;
    collect(n);
  endtask

  initial begin
    int n;
    int base;
    logic [15:0] rts;
    rst_n = 1'b0; instructions_valid = 1'b0;
    opcode_in = '0; op_a_owner_in = '0; op_b_owner_in = '0; rt_in = '0; ra_owner = '0; rb_owner = '0;
    op_a_local_dep = '0; op_b_local_dep = '0; uses_rb = '0; ra_busy = '0; rb_busy = '0;
    ra_value = '0; rb_value = '0; rob_output_valid = '0; rob_output_values = '0;
    fxu_0_full = 1'b0; fxu_1_full = 1'b0; lsu_full = 1'b0; branch_full = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_num_slots", num_slots, 4'd8);
    chk("reset_out_valid", out_valid, 4'd0);
    chk("reset_out_a_value", out_a_value[31:0], 32'd0);
    rst_n = 1'b1;

    // Four independent FXU ops: two dispatch per cycle.
    set_group(16'h1111, 16'h3210, 16'h0005, 1'b1);
    step(n); chk("fxu_enq_ndisp", n, 0); chk("fxu_enq_slots", num_slots, 4'd4);
    step(n); chk("fxu_first_ndisp", n, 2);
    step(n); chk("fxu_second_ndisp", n, 2); chk("fxu_slots_back", num_slots, 4'd8);

    // Mixed group with LSU blocked: head stalls at the LSU op.
    lsu_full = 1'b1;
    set_group(16'h2C81, 16'h7654, 16'h0022, 1'b1);
    step(n); chk("mix_enq_ndisp", n, 0);
    step(n); chk("mix_stall1_ndisp", n, 1);
    step(n); chk("mix_stall2_ndisp", n, 0);
    step(n); chk("mix_stall3_ndisp", n, 0);
    lsu_full = 1'b0;
    step(n); chk("mix_release_ndisp", n, 3); chk("mix_slots", num_slots, 4'd8);

    // Busy register, ROB not ready: pending tag 3.
    base = sb.size();
    set_group(16'h1111, 16'hBA98, 16'h0033, 1'b1);
    ra_busy = 4'b0001; ra_owner = 16'h0003; fix_a(base, 1'b0, 16'h0, 4'h3);
    step(n); step(n); chk("pend_ndisp", n, 2);
    step(n); chk("pend_tail_ndisp", n, 2);

    // Busy register forwarded by ROB at enqueue.
    base = sb.size();
    set_group(16'h1111, 16'hFEDC, 16'h0044, 1'b1);
    ra_busy = 4'b0001; ra_owner = 16'h0003; fix_a(base, 1'b1, 16'h1234, 4'h3);
    rob_output_valid[3] = 1'b1; rob_output_values[3*16 +: 16] = 16'h1234;
    step(n); rob_output_valid = '0;
    step(n); chk("fwd_enq_ndisp", n, 2);
    step(n); chk("fwd_enq_tail_ndisp", n, 2);

    // Pending operand forwarded by ROB in the dispatch cycle.
    base = sb.size();
    set_group(16'h1111, 16'h3210, 16'h0055, 1'b1);
    ra_busy = 4'b0010; ra_owner = 16'h0050; fix_a(base + 1, 1'b1, 16'hBEEF, 4'h5);
    step(n);
    rob_output_valid[5] = 1'b1; rob_output_values[5*16 +: 16] = 16'hBEEF;
    step(n); chk("fwd_disp_ndisp", n, 2);
    rob_output_valid = '0;
    step(n); chk("fwd_disp_tail_ndisp", n, 2);

    // Fill with all units full, drop a third group, wake an operand while queued, then drain.
    fxu_0_full = 1'b1; fxu_1_full = 1'b1; lsu_full = 1'b1; branch_full = 1'b1;
    base = sb.size();
    set_group(16'hC821, 16'hBA98, 16'h0A0A, 1'b1);
    ra_busy = 4'b0001; ra_owner = 16'h0007; fix_a(base, 1'b1, 16'h7777, 4'h7);
    step(n); chk("fill1_slots", num_slots, 4'd4); chk("fill1_ndisp", n, 0);
    base = sb.size();
    set_group(16'hC821, 16'hFEDC, 16'h0B0B, 1'b1);
    op_a_local_dep = 4'b0100; op_a_owner_in = 16'h0900; fix_a(base + 2, 1'b0, 16'h0, 4'h9);
    step(n); chk("fill2_slots", num_slots, 4'd0); chk("fill2_ndisp", n, 0);
    set_group(16'hC821, 16'h5555, 16'h0C0C, 1'b0);
    rob_output_valid[7] = 1'b1; rob_output_values[7*16 +: 16] = 16'h7777;
    step(n); chk("drop_slots", num_slots, 4'd0); chk("drop_ndisp", n, 0);
    rob_output_valid = '0;
    fxu_0_full = 1'b0; fxu_1_full = 1'b0; lsu_full = 1'b0; branch_full = 1'b0;
    step(n); chk("drain1_ndisp", n, 4);
    step(n); chk("drain2_ndisp", n, 4); chk("drain_slots", num_slots, 4'd8);
    chk("drain_sb_empty", sb.size(), 0);

    // Five back-to-back groups with continuous draining across pointer wrap.
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 4; i++) rts[i*4 +: 4] = 4'((g * 4 + i) % 16);
      set_group(16'hC821, rts, 16'(16'h0100 * (g + 1)), 1'b1);
      step(n); chk("wrap_ndisp", n, (g == 0) ? 0 : 4);
    end
    step(n); chk("wrap_last_ndisp", n, 4);
    step(n); chk("wrap_idle_ndisp", n, 0);
    chk("wrap_slots", num_slots, 4'd8);
    chk("wrap_sb_empty", sb.size(), 0);

    // Reset mid-operation discards queued entries.
    fxu_0_full = 1'b1; fxu_1_full = 1'b1; lsu_full = 1'b1; branch_full = 1'b1;
    set_group(16'hC821, 16'h3210, 16'h0D0D, 1'b0);
    step(n); chk("prereset_slots", num_slots, 4'd4);
    rst_n = 1'b0;
    step(n); chk("midreset_slots", num_slots, 4'd8);
    rst_n = 1'b1;
    fxu_0_full = 1'b0; fxu_1_full = 1'b0; lsu_full = 1'b0; branch_full = 1'b0;
    step(n); chk("postreset_ndisp", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
